// File: rtl/sb_prog_clk_divider.sv
`default_nettype none
// ============================================================================
// Module   : sb_prog_clk_divider
// Purpose  : Runtime-programmable integer divider for the sideband clocking
//            path. Divides i_pll_clk by N (2 .. 2^DIV_W-1) and produces a
//            flop-driven, glitch-free divided clock plus a tick strobe on
//            each rising edge. Ratio changes are handshaked and take effect
//            only on a period boundary. Dropping the enable lets the current
//            period finish before parking the output low.
// Ports    :
//   i_pll_clk     in   1      sole clock
//   i_rst_n       in   1      asynchronous active-low reset
//   i_clk_en      in   1      run request (level)
//   i_div_ratio   in   DIV_W  requested ratio, sampled when i_div_load=1
//   i_div_load    in   1      single-cycle load strobe
//   o_divided_clk out  1      divided clock (flop output)
//   o_tick        out  1      one-cycle pulse with each divided-clock rise
//   o_load_ack    out  1      one-cycle pulse when a new ratio becomes active
//   o_cfg_err     out  1      one-cycle pulse for a load with ratio 0 or 1
//   o_running     out  1      high while not idle
// Revision : 1.0 - initial release
// ============================================================================
module sb_prog_clk_divider #(
  parameter int DIV_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             i_pll_clk,
  input  logic             i_rst_n,
  input  logic             i_clk_en,
  input  logic [DIV_W-1:0] i_div_ratio,
  input  logic             i_div_load,
  output logic             o_divided_clk,
  output logic             o_tick,
  output logic             o_load_ack,
  output logic             o_cfg_err,
  output logic             o_running
);

  // --------------------------------------------------------------------------
  // Elaboration-time guard on the reset ratio
  // --------------------------------------------------------------------------
  if ((DEFAULT_DIV < 2) || (DEFAULT_DIV > ((2 ** DIV_W) - 1))) begin : g_bad_default_div
    $error("sb_prog_clk_divider: DEFAULT_DIV must lie in 2 .. 2^DIV_W-1");
  end

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0]       c_ST_IDLE  = 2'd0;
  localparam logic [1:0]       c_ST_RUN   = 2'd1;
  localparam logic [1:0]       c_ST_DRAIN = 2'd2;

  localparam logic [DIV_W-1:0] c_DEFAULT  = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] c_ONE      = DIV_W'(1);
  localparam logic [DIV_W-1:0] c_TWO      = DIV_W'(2);
  localparam logic [DIV_W:0]   c_ONE_X    = (DIV_W+1)'(1);

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]       r_state;
  logic [DIV_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_n_act;
  logic [DIV_W-1:0] r_n_pend;
  logic             r_pend_vld;
  logic             r_clk_q;
  logic             r_tick;
  logic             r_load_ack;
  logic             r_cfg_err;
  logic             r_running;

  // --------------------------------------------------------------------------
  // Combinational next-state
  // --------------------------------------------------------------------------
  logic [DIV_W:0]   w_high_time;
  logic [DIV_W:0]   w_cnt_inc;
  logic             w_boundary;
  logic             w_run_like;
  logic             w_load_ok;
  logic             w_load_bad;
  logic             w_apply;

  logic [1:0]       w_state_nxt;
  logic [DIV_W-1:0] w_cnt_nxt;
  logic             w_clk_nxt;
  logic             w_tick_nxt;
  logic [DIV_W-1:0] w_n_act_nxt;
  logic [DIV_W-1:0] w_n_pend_nxt;
  logic             w_pend_vld_nxt;

  // High time is ceil(N/2); one extra bit keeps the +1 from wrapping at the
  // largest legal ratio.
  assign w_high_time = ({1'b0, r_n_act} + c_ONE_X) >> 1;
  assign w_cnt_inc   = {1'b0, r_cnt} + c_ONE_X;

  // r_n_act is never below 2, so n_act-1 never underflows.
  assign w_boundary  = (r_state != c_ST_IDLE) && (r_cnt == (r_n_act - c_ONE));

  // DRAIN with the enable back high behaves exactly like RUN for this cycle,
  // so a re-enable (even on the boundary cycle itself) leaves no phase gap.
  assign w_run_like  = (r_state == c_ST_RUN) ||
                       ((r_state == c_ST_DRAIN) && i_clk_en);

  assign w_load_ok   = i_div_load && (i_div_ratio >= c_TWO);
  assign w_load_bad  = i_div_load && (i_div_ratio <  c_TWO);

  // A pending ratio is taken on any idle edge, or on a counting boundary.
  assign w_apply     = r_pend_vld && ((r_state == c_ST_IDLE) || w_boundary);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clk_nxt   = r_clk_q;
    w_tick_nxt  = 1'b0;

    case (r_state)
      c_ST_IDLE: begin
        w_cnt_nxt = '0;
        w_clk_nxt = 1'b0;
        if (i_clk_en) begin
          w_clk_nxt   = 1'b1;
          w_tick_nxt  = 1'b1;
          w_state_nxt = c_ST_RUN;
        end
      end

      c_ST_RUN, c_ST_DRAIN: begin
        if (w_boundary) begin
          w_cnt_nxt = '0;
          if (w_run_like) begin
            // Start the next period; a low enable here still lets this
            // whole period run out before parking.
            w_clk_nxt   = 1'b1;
            w_tick_nxt  = 1'b1;
            w_state_nxt = i_clk_en ? c_ST_RUN : c_ST_DRAIN;
          end else begin
            // Drain complete: park low without starting a new period.
            w_clk_nxt   = 1'b0;
            w_state_nxt = c_ST_IDLE;
          end
        end else begin
          w_cnt_nxt   = w_cnt_inc[DIV_W-1:0];
          w_clk_nxt   = (w_cnt_inc < w_high_time);
          w_state_nxt = i_clk_en ? c_ST_RUN : c_ST_DRAIN;
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_clk_nxt   = 1'b0;
        w_state_nxt = c_ST_IDLE;
      end
    endcase
  end

  // Ratio handshake. The apply decision only looks at the registered pending
  // flag, so a load arriving in the same cycle as a boundary (or an apply)
  // lands in n_pend and waits for the following boundary.
  always_comb begin
    w_n_act_nxt    = r_n_act;
    w_n_pend_nxt   = r_n_pend;
    w_pend_vld_nxt = r_pend_vld;

    if (w_apply) begin
      w_n_act_nxt    = r_n_pend;
      w_pend_vld_nxt = 1'b0;
    end

    if (w_load_ok) begin
      w_n_pend_nxt   = i_div_ratio;
      w_pend_vld_nxt = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge i_pll_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= c_ST_IDLE;
      r_cnt      <= '0;
      r_n_act    <= c_DEFAULT;
      r_n_pend   <= c_DEFAULT;
      r_pend_vld <= 1'b0;
      r_clk_q    <= 1'b0;
      r_tick     <= 1'b0;
      r_load_ack <= 1'b0;
      r_cfg_err  <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_n_act    <= w_n_act_nxt;
      r_n_pend   <= w_n_pend_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_clk_q    <= w_clk_nxt;
      r_tick     <= w_tick_nxt;
      r_load_ack <= w_apply;
      r_cfg_err  <= w_load_bad;
      // Registered copy of (next state != IDLE) so the output is flop-driven
      // while still tracking the state register exactly.
      r_running  <= (w_state_nxt != c_ST_IDLE);
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_divided_clk = r_clk_q;
  assign o_tick        = r_tick;
  assign o_load_ack    = r_load_ack;
  assign o_cfg_err     = r_cfg_err;
  assign o_running     = r_running;

endmodule
`default_nettype wire

// File: tb/tb_sb_prog_clk_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_sb_prog_clk_divider
// Purpose  : Directed bench for sb_prog_clk_divider. Each step drives the
//            inputs, pushes the expected post-edge output vector
//            {clk, tick, ack, err, running} into a scoreboard queue, then
//            pops and compares it after the clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sb_prog_clk_divider;

  localparam int DIV_W = 8;

  logic             clk;
  logic             rst_n;
  logic             clk_en;
  logic [DIV_W-1:0] div_ratio;
  logic             div_load;
  logic             divided_clk;
  logic             tick;
  logic             load_ack;
  logic             cfg_err;
  logic             running;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } sb_t;

  sb_t q_sb[$];
  int  n_assert = 0;
  int  n_fail   = 0;

  sb_prog_clk_divider #(
    .DIV_W       (DIV_W),
    .DEFAULT_DIV (4)
  ) u_dut (
    .i_pll_clk     (clk),
    .i_rst_n       (rst_n),
    .i_clk_en      (clk_en),
    .i_div_ratio   (div_ratio),
    .i_div_load    (div_load),
    .o_divided_clk (divided_clk),
    .o_tick        (tick),
    .o_load_ack    (load_ack),
    .o_cfg_err     (cfg_err),
    .o_running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pop the oldest expectation and compare it with the live outputs.
  task automatic sample();
    sb_t        item;
    logic [4:0] obs;
    if (q_sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard_empty: observed=0 entries required>=1");
    end else begin
      item = q_sb.pop_front();
      obs  = {divided_clk, tick, load_ack, cfg_err, running};
      n_assert++;
      assert (obs === item.exp) else begin
        n_fail++;
        $error("FAIL %s: observed={clk,tick,ack,err,run}=%b expected=%b",
               item.tag, obs, item.exp);
      end
    end
  endtask

  task automatic push_exp(input logic [4:0] exp, input string tag);
    sb_t item;
    item.tag = tag;
    item.exp = exp;
    q_sb.push_back(item);
  endtask

  // One clock step: drive inputs, expect 'exp' after the edge.
  task automatic cyc(input logic en, input logic ld, input logic [DIV_W-1:0] ratio,
                     input logic [4:0] exp, input string tag);
    clk_en    = en;
    div_load  = ld;
    div_ratio = ratio;
    push_exp(exp, tag);
    @(posedge clk);
    #1;
    div_load = 1'b0;
    sample();
  endtask

  // Remaining cycles of a period (cnt = 1 .. n-1): high while cnt < ceil(n/2).
  task automatic tail(input int n, input string tag);
    int h;
    h = (n + 1) / 2;
    for (int c = 1; c < n; c++) begin
      cyc(1'b1, 1'b0, '0, {((c < h) ? 1'b1 : 1'b0), 4'b0001}, tag);
    end
  endtask

  // A whole period starting at the boundary edge.
  task automatic period(input int n, input logic ack, input string tag);
    cyc(1'b1, 1'b0, '0, {2'b11, ack, 2'b01}, tag);
    tail(n, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    clk_en    = 1'b0;
    div_load  = 1'b0;
    div_ratio = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    push_exp(5'b00000, "reset_state");
    sample();
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, '0, 5'b00000, "idle_after_reset");

    // Default ratio 4: first rise on the enabling edge, then 1100 repeating
    cyc(1'b1, 1'b0, '0, 5'b11001, "en_first_rise");
    tail(4, "div4_tail");
    period(4, 1'b0, "div4_p1");
    period(4, 1'b0, "div4_p2");

    // 4 -> 6 mid-period: current period intact, ack on the boundary
    cyc(1'b1, 1'b0, '0,    5'b11001, "chg6_start");
    cyc(1'b1, 1'b1, 8'd6,  5'b10001, "chg6_load");
    cyc(1'b1, 1'b0, '0,    5'b00001, "chg6_cnt2");
    cyc(1'b1, 1'b0, '0,    5'b00001, "chg6_cnt3");
    cyc(1'b1, 1'b0, '0,    5'b11101, "chg6_ack");
    tail(6, "div6_tail");
    period(6, 1'b0, "div6_p1");

    // Illegal ratios 0 and 1: error pulses, no ack, ratio unchanged
    cyc(1'b1, 1'b0, '0,    5'b11001, "bad_start");
    cyc(1'b1, 1'b1, 8'd0,  5'b10011, "bad_ratio0");
    cyc(1'b1, 1'b1, 8'd1,  5'b10011, "bad_ratio1");
    cyc(1'b1, 1'b0, '0,    5'b00001, "bad_cnt3");
    cyc(1'b1, 1'b0, '0,    5'b00001, "bad_cnt4");
    cyc(1'b1, 1'b0, '0,    5'b00001, "bad_cnt5");
    period(6, 1'b0, "bad_still6");

    // Stop at cnt=1 with N=6: period completes, then parks low
    cyc(1'b1, 1'b0, '0, 5'b11001, "stop_start");
    cyc(1'b1, 1'b0, '0, 5'b10001, "stop_cnt1");
    cyc(1'b0, 1'b0, '0, 5'b10001, "stop_cnt2");
    cyc(1'b0, 1'b0, '0, 5'b00001, "stop_cnt3");
    cyc(1'b0, 1'b0, '0, 5'b00001, "stop_cnt4");
    cyc(1'b0, 1'b0, '0, 5'b00001, "stop_cnt5");
    cyc(1'b0, 1'b0, '0, 5'b00000, "stop_boundary");
    cyc(1'b0, 1'b0, '0, 5'b00000, "stop_parked1");
    cyc(1'b0, 1'b0, '0, 5'b00000, "stop_parked2");

    // Odd ratio 5 loaded in IDLE: ack on the next edge, then 11100
    cyc(1'b0, 1'b1, 8'd5, 5'b00000, "idle_load5");
    cyc(1'b0, 1'b0, '0,   5'b00100, "idle_ack5");
    cyc(1'b1, 1'b0, '0,   5'b11001, "div5_start");
    tail(5, "div5_tail");
    period(5, 1'b0, "div5_p1");

    // Back-to-back loads 8 then 10 in one period: single ack, 10 wins
    cyc(1'b1, 1'b0, '0,    5'b11001, "b2b_start");
    cyc(1'b1, 1'b1, 8'd8,  5'b10001, "b2b_load8");
    cyc(1'b1, 1'b1, 8'd10, 5'b10001, "b2b_load10");
    cyc(1'b1, 1'b0, '0,    5'b00001, "b2b_cnt3");
    cyc(1'b1, 1'b0, '0,    5'b00001, "b2b_cnt4");
    cyc(1'b1, 1'b0, '0,    5'b11101, "b2b_ack");
    tail(10, "div10_tail");

    // Load on the boundary edge itself: applies at the following boundary
    cyc(1'b1, 1'b1, 8'd4, 5'b11001, "bnd_load4");
    tail(10, "bnd_still10");
    cyc(1'b1, 1'b0, '0,   5'b11101, "bnd_ack4");
    tail(4, "bnd_div4");

    // Re-enable during DRAIN: no phase gap
    cyc(1'b1, 1'b0, '0, 5'b11001, "reen_start");
    cyc(1'b0, 1'b0, '0, 5'b10001, "reen_drain");
    cyc(1'b1, 1'b0, '0, 5'b00001, "reen_back");
    cyc(1'b1, 1'b0, '0, 5'b00001, "reen_cnt3");
    cyc(1'b1, 1'b0, '0, 5'b11001, "reen_tick");
    tail(4, "reen_tail");

    // Asynchronous reset mid-high with a pending load
    cyc(1'b1, 1'b0, '0,   5'b11001, "rst_start");
    cyc(1'b1, 1'b1, 8'd7, 5'b10001, "rst_load7");
    rst_n  = 1'b0;
    clk_en = 1'b0;
    #2;
    push_exp(5'b00000, "rst_async_drop");
    sample();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, '0, 5'b00000, "rst_no_ack1");
    cyc(1'b0, 1'b0, '0, 5'b00000, "rst_no_ack2");
    cyc(1'b1, 1'b0, '0, 5'b11001, "rst_restart");
    tail(4, "rst_default4");
    period(4, 1'b0, "rst_default4_p");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
